// File: rtl/kl11_pkg.sv
// Shared definitions for the KL11 console interface: register offsets,
// CSR bit positions, FSM encodings and the bus byte-lane helper.
package kl11_pkg;

  localparam logic [2:0] OFF_RCSR = 3'd0;
  localparam logic [2:0] OFF_RBUF = 3'd2;
  localparam logic [2:0] OFF_XCSR = 3'd4;
  localparam logic [2:0] OFF_XBUF = 3'd6;

  localparam int BIT_DONE    = 7;
  localparam int BIT_IE      = 6;
  localparam int BIT_MAINT   = 0;
  localparam int BIT_OVERRUN = 15;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Byte reads return the addressed byte right-justified.
  function automatic logic [15:0] byte_lane(input logic [15:0] word,
                                            input logic        byte_op,
                                            input logic        odd);
    if (!byte_op) return word;
    return odd ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
  endfunction

endpackage

// File: rtl/kl11_uart_rx.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling from a validated
// start bit, one-cycle valid pulse with the byte on a good stop bit.
module kl11_uart_rx
  import kl11_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line,
  output logic       valid,
  output logic [7:0] data
);

  localparam logic [15:0] HALF = (CLK_DIV >> 1) - 16'd1;
  localparam logic [15:0] FULL = CLK_DIV - 16'd1;

  logic        sync1, line_s, line_prev;
  rx_state_e   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        ferr, ferr_n;
  logic        valid_n;
  logic [7:0]  data_n;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      line_s    <= 1'b1;
      line_prev <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      ferr      <= 1'b0;
      valid     <= 1'b0;
      data      <= '0;
    end else begin
      sync1     <= line;
      line_s    <= sync1;
      line_prev <= line_s;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      ferr      <= ferr_n;
      valid     <= valid_n;
      data      <= data_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    ferr_n  = ferr;
    valid_n = 1'b0;
    data_n  = data;
    unique case (state)
      RX_IDLE: begin
        if (line_prev && !line_s) begin
          state_n = RX_START;
          cnt_n   = HALF;
        end
      end
      RX_START: begin
        if (cnt == '0) begin
          if (line_s) begin
            state_n = RX_IDLE;
          end else begin
            state_n = RX_DATA;
            cnt_n   = FULL;
            idx_n   = '0;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt == '0) begin
          shift_n = {line_s, shift[7:1]};
          cnt_n   = FULL;
          if (idx == 3'd7) state_n = RX_STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      RX_STOP: begin
        // After a framing error, hold here until the line returns high.
        if (ferr) begin
          if (line_s) begin
            state_n = RX_IDLE;
            ferr_n  = 1'b0;
          end
        end else if (cnt == '0) begin
          if (line_s) begin
            valid_n = 1'b1;
            data_n  = shift;
            state_n = RX_IDLE;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/kl11_console.sv
// DL11/KL11 console: RCSR/RBUF/XCSR/XBUF on the iopage bus, an 8N1
// transmitter, and the kl11_uart_rx receiver with maintenance loopback.
module kl11_console
  import kl11_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd434,
  parameter logic [12:0] BASE    = 13'o17560
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] iopage_addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        decode,
  input  logic        iopage_rd,
  input  logic        iopage_wr,
  input  logic        iopage_byte_op,
  input  logic        rxd,
  output logic        txd,
  output logic        rx_int,
  output logic        tx_int
);

  localparam logic [15:0] FULL = CLK_DIV - 16'd1;

  logic        rx_done, rx_ie, overrun, tx_ready, tx_ie, maint;
  logic [7:0]  rbuf, tx_buf;
  logic [2:0]  reg_off;
  logic        bus_rd, lo_we, rbuf_rd, xbuf_wr;
  logic [15:0] word;
  logic        rx_valid;
  logic [7:0]  rx_byte;

  tx_state_e   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        txd_n, tx_end;

  assign decode  = ({1'b0, iopage_addr} >= {1'b0, BASE}) &&
                   ({1'b0, iopage_addr} <= {1'b0, BASE} + 14'd7);
  // The window is word aligned, so the low address bits give the offset.
  assign reg_off = {iopage_addr[2:1] - BASE[2:1], 1'b0};
  assign bus_rd  = decode && iopage_rd;
  assign lo_we   = decode && iopage_wr && !(iopage_byte_op && iopage_addr[0]);
  assign rbuf_rd = bus_rd && (reg_off == OFF_RBUF);
  assign xbuf_wr = lo_we && (reg_off == OFF_XBUF);

  always_comb begin
    word = '0;
    unique case (reg_off)
      OFF_RCSR: begin
        word[BIT_DONE] = rx_done;
        word[BIT_IE]   = rx_ie;
      end
      OFF_RBUF: begin
        word[7:0]         = rbuf;
        word[BIT_OVERRUN] = overrun;
      end
      OFF_XCSR: begin
        word[BIT_DONE]  = tx_ready;
        word[BIT_IE]    = tx_ie;
        word[BIT_MAINT] = maint;
      end
      default: word = '0;
    endcase
    data_out = bus_rd ? byte_lane(word, iopage_byte_op, iopage_addr[0]) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_done  <= 1'b0;
      rx_ie    <= 1'b0;
      overrun  <= 1'b0;
      rbuf     <= '0;
      tx_ready <= 1'b1;
      tx_ie    <= 1'b0;
      maint    <= 1'b0;
      tx_buf   <= '0;
      rx_int   <= 1'b0;
      tx_int   <= 1'b0;
    end else begin
      rx_int <= rx_done & rx_ie;
      tx_int <= tx_ready & tx_ie;
      // A completing frame beats a concurrent RBUF read.
      if (rx_valid) begin
        rbuf    <= rx_byte;
        rx_done <= 1'b1;
        overrun <= rx_done & ~rbuf_rd;
      end else if (rbuf_rd) begin
        rx_done <= 1'b0;
        overrun <= 1'b0;
      end
      if (lo_we && reg_off == OFF_RCSR) rx_ie <= data_in[BIT_IE];
      if (lo_we && reg_off == OFF_XCSR) begin
        tx_ie <= data_in[BIT_IE];
        maint <= data_in[BIT_MAINT];
      end
      if (tx_end) begin
        tx_ready <= 1'b1;
      end else if (xbuf_wr && tx_ready) begin
        tx_buf   <= data_in[7:0];
        tx_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
    end
  end

  // TX_READY low while idle means a byte is waiting in tx_buf.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    tx_end     = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (!tx_ready) begin
          tx_state_n = TX_START;
          tx_cnt_n   = FULL;
          tx_shift_n = tx_buf;
          txd_n      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = FULL;
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_n = FULL;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          tx_state_n = TX_IDLE;
          tx_end     = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  kl11_uart_rx #(
    .CLK_DIV(CLK_DIV)
  ) u_rx (
    .clk  (clk),
    .reset(reset),
    .line (maint ? txd : rxd),
    .valid(rx_valid),
    .data (rx_byte)
  );

endmodule

// File: tb/tb_kl11_console.sv
// Directed plus randomized bench for kl11_console at CLK_DIV=8, checked
// against a register-level model of the console kept in the bench.
module tb_kl11_console;

  localparam logic [15:0] DIV    = 16'd8;
  localparam logic [12:0] BASE   = 13'o17560;
  localparam logic [12:0] A_RCSR = BASE;
  localparam logic [12:0] A_RBUF = BASE + 13'd2;
  localparam logic [12:0] A_XCSR = BASE + 13'd4;
  localparam logic [12:0] A_XBUF = BASE + 13'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] iopage_addr;
  logic [15:0] data_in, data_out;
  logic        decode, iopage_rd, iopage_wr, iopage_byte_op;
  logic        rxd, txd, rx_int, tx_int;

  int vectors = 0;
  int errors  = 0;

  // Model of the programmer-visible state.
  logic       m_done, m_ie, m_ovr, m_ready, m_txie, m_maint;
  logic [7:0] m_rbuf;

  kl11_console #(.CLK_DIV(DIV), .BASE(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .iopage_addr   (iopage_addr),
    .data_in       (data_in),
    .data_out      (data_out),
    .decode        (decode),
    .iopage_rd     (iopage_rd),
    .iopage_wr     (iopage_wr),
    .iopage_byte_op(iopage_byte_op),
    .rxd           (rxd),
    .txd           (txd),
    .rx_int        (rx_int),
    .tx_int        (tx_int)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_rcsr();
    return {8'h00, m_done, m_ie, 6'b0};
  endfunction
  function automatic logic [15:0] exp_rbuf();
    return {m_ovr, 7'b0, m_rbuf};
  endfunction
  function automatic logic [15:0] exp_xcsr();
    return {8'h00, m_ready, m_txie, 5'b0, m_maint};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %06o expected %06o", tag, obs, exp);
    end
  endtask

  // Combinational look at a register between edges; no side effects.
  task automatic peek(input logic [12:0] a, input logic bop, output logic [15:0] d);
    iopage_addr = a; iopage_byte_op = bop; iopage_rd = 1'b1;
    #1 d = data_out;
    iopage_rd = 1'b0; iopage_byte_op = 1'b0;
  endtask

  task automatic read_commit(input logic [12:0] a, output logic [15:0] d);
    @(negedge clk);
    iopage_addr = a; iopage_rd = 1'b1;
    #1 d = data_out;
    @(posedge clk);
    #1 iopage_rd = 1'b0;
  endtask

  task automatic bus_write(input logic [12:0] a, input logic [15:0] d, input logic bop);
    @(negedge clk);
    iopage_addr = a; data_in = d; iopage_byte_op = bop; iopage_wr = 1'b1;
    @(posedge clk);
    #1 iopage_wr = 1'b0; iopage_byte_op = 1'b0;
  endtask

  task automatic model_read_rbuf();
    m_done = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // Drive one frame on rxd (plus a short idle tail) while checking the
  // interrupt lag rule every cycle; then fold the byte into the model.
  task automatic send_rx(input logic [7:0] b);
    logic [9:0]  bits;
    logic [15:0] r;
    logic        prev_int;
    logic        was_done;
    int          first;
    bits     = {1'b1, b, 1'b0};
    was_done = m_done;
    first    = -1;
    prev_int = 1'b0;
    for (int c = 0; c < 88; c++) begin
      @(negedge clk);
      rxd = (c < 80) ? bits[c/8] : 1'b1;
      peek(A_RCSR, 1'b0, r);
      if (c > 0) check("rx_int_lag", rx_int, prev_int);
      prev_int = r[7] & m_ie;
      if (first < 0 && r[7]) first = c;
    end
    if (!was_done) check("rx_done_in_stop_bit", (first >= 72 && first <= 87), 1);
    m_ovr  = m_done;
    m_done = 1'b1;
    m_rbuf = b;
    peek(A_RCSR, 1'b0, r);
    check("rcsr_after_rx", r, exp_rcsr());
    peek(A_RBUF, 1'b0, r);
    check("rbuf_after_rx", r, exp_rbuf());
  endtask

  // mode 0: plain frame; 1: XBUF write mid-frame; 2: XBUF write on the
  // edge that ends the stop bit. Both writes must be ignored.
  task automatic send_tx(input logic [7:0] b, input int mode);
    logic [9:0]  fr;
    logic [15:0] r;
    fr = {1'b1, b, 1'b0};
    bus_write(A_XBUF, {8'($urandom), b}, 1'b0);
    m_ready = 1'b0;
    peek(A_XCSR, 1'b0, r);
    check("xcsr_busy", r, exp_xcsr());
    @(negedge clk);
    check("tx_start_latency", txd, 1'b1);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      iopage_wr = 1'b0;
      check("tx_bit", txd, fr[c/8]);
      if (c == 79) begin
        peek(A_XCSR, 1'b0, r);
        check("xcsr_before_stop_end", r, exp_xcsr());
      end
      if ((mode == 1 && c == 40) || (mode == 2 && c == 79)) begin
        iopage_addr = A_XBUF; data_in = {8'h00, ~b}; iopage_wr = 1'b1;
      end
    end
    @(negedge clk);
    iopage_wr = 1'b0;
    m_ready = 1'b1;
    peek(A_XCSR, 1'b0, r);
    check("xcsr_after_stop_end", r, exp_xcsr());
    check("tx_int_lag0", tx_int, 1'b0);
    @(negedge clk);
    check("tx_int_lag1", tx_int, m_txie);
    if (mode != 0) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        check("tx_stays_idle", txd, 1'b1);
      end
    end
  endtask

  task automatic glitch_and_idle(input string tag);
    logic [15:0] r;
    for (int c = 0; c < 43; c++) begin
      @(negedge clk);
      rxd = (c < 3) ? 1'b0 : 1'b1;
    end
    peek(A_RCSR, 1'b0, r);
    check(tag, r, exp_rcsr());
  endtask

  initial begin
    logic [15:0] r;
    logic [7:0]  b;
    logic        got;

    reset = 1'b1; iopage_addr = '0; data_in = '0;
    iopage_rd = 1'b0; iopage_wr = 1'b0; iopage_byte_op = 1'b0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_done = 0; m_ie = 0; m_ovr = 0; m_rbuf = '0;
    m_ready = 1; m_txie = 0; m_maint = 0;

    // Reset state and address decode
    @(negedge clk);
    peek(A_RCSR, 1'b0, r); check("reset_rcsr", r, 16'o000000);
    peek(A_XCSR, 1'b0, r); check("reset_xcsr", r, 16'o000200);
    peek(A_RBUF, 1'b0, r); check("reset_rbuf", r, 16'o000000);
    peek(A_XBUF, 1'b0, r); check("xbuf_reads_zero", r, 16'o000000);
    check("reset_txd", txd, 1'b1);
    check("reset_rx_int", rx_int, 1'b0);
    check("reset_tx_int", tx_int, 1'b0);
    iopage_addr = A_XCSR; #1 check("no_rd_data_zero", data_out, 16'o000000);
    iopage_addr = BASE + 13'd7; #1 check("decode_top", decode, 1'b1);
    iopage_addr = BASE + 13'd8; #1 check("decode_above", decode, 1'b0);
    iopage_addr = BASE - 13'd1; #1 check("decode_below", decode, 1'b0);
    peek(A_XCSR, 1'b1, r); check("byte_read_even", r, 16'o000200);
    peek(A_XCSR + 13'd1, 1'b1, r); check("byte_read_odd", r, 16'o000000);

    // Transmit 0101 (frame 0,1,0,0,0,0,0,1,0,1)
    send_tx(8'o101, 0);

    // Receive 0x5A, then clear it with an RBUF read
    send_rx(8'h5A);
    check("rbuf_5a", exp_rbuf(), 16'o000132);
    read_commit(A_RBUF, r); check("rbuf_read_5a", r, 16'o000132);
    model_read_rbuf();
    peek(A_RCSR, 1'b0, r); check("rcsr_cleared", r, exp_rcsr());

    // Odd byte write leaves RX_IE alone; word write sets it
    bus_write(A_RCSR + 13'd1, 16'h4040, 1'b1);
    peek(A_RCSR, 1'b0, r); check("odd_byte_write_ignored", r, exp_rcsr());
    bus_write(A_RCSR, 16'o000100, 1'b0);
    m_ie = 1'b1;
    peek(A_RCSR, 1'b0, r); check("rx_ie_set", r, exp_rcsr());
    send_rx(8'($urandom));
    @(negedge clk); check("rx_int_high", rx_int, 1'b1);
    read_commit(A_RBUF, r); check("rbuf_read_ie", r, exp_rbuf());
    model_read_rbuf();
    @(negedge clk); check("rx_int_lag_hold", rx_int, 1'b1);
    @(negedge clk); check("rx_int_cleared", rx_int, 1'b0);
    bus_write(A_RCSR, 16'o000000, 1'b0);
    m_ie = 1'b0;

    // Overrun: two bytes without a read
    send_rx(8'($urandom));
    send_rx(8'($urandom));
    read_commit(A_RBUF, r); check("rbuf_overrun", r, exp_rbuf());
    model_read_rbuf();
    peek(A_RBUF, 1'b0, r); check("overrun_cleared", r, exp_rbuf());
    peek(A_RCSR, 1'b0, r); check("rcsr_after_overrun", r, exp_rcsr());

    // Random receive traffic with random read-back
    for (int i = 0; i < 4; i++) begin
      send_rx(8'($urandom));
      if ($urandom_range(1, 0) == 1) begin
        read_commit(A_RBUF, r); check("rbuf_random", r, exp_rbuf());
        model_read_rbuf();
      end
    end
    read_commit(A_RBUF, r); check("rbuf_drain", r, exp_rbuf());
    model_read_rbuf();

    // TX interrupt enable and ignored XBUF writes
    bus_write(A_XCSR, 16'o000100, 1'b0);
    m_txie = 1'b1;
    @(negedge clk); check("tx_int_lag_before", tx_int, 1'b0);
    @(negedge clk); check("tx_int_on", tx_int, 1'b1);
    send_tx(8'($urandom), 1);
    send_tx(8'($urandom), 2);
    send_tx(8'($urandom), 0);

    // Maintenance loopback
    bus_write(A_XCSR, 16'o000001, 1'b0);
    m_txie = 1'b0; m_maint = 1'b1;
    peek(A_XCSR, 1'b0, r); check("xcsr_maint", r, exp_xcsr());
    b = 8'h33;
    for (int k = 0; k < 2; k++) begin
      send_tx(b, 0);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        peek(A_RCSR, 1'b0, r);
        got = r[7];
      end
      check("loopback_done", got, 1'b1);
      m_done = 1'b1; m_rbuf = b;
      read_commit(A_RBUF, r); check("loopback_rbuf", r, exp_rbuf());
      model_read_rbuf();
      b = 8'($urandom);
    end
    glitch_and_idle("maint_ignores_rxd");
    bus_write(A_XCSR, 16'o000000, 1'b0);
    m_maint = 1'b0;
    glitch_and_idle("glitch_no_rx_done");

    // Reset mid-frame on both directions
    bus_write(A_XBUF, 16'o000000, 1'b0);
    m_ready = 1'b0;
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    check("txd_low_mid_frame", txd, 1'b0);
    reset = 1'b1; rxd = 1'b1;
    @(negedge clk);
    check("reset_forces_txd", txd, 1'b1);
    reset = 1'b0;
    m_done = 0; m_ie = 0; m_ovr = 0; m_rbuf = '0;
    m_ready = 1; m_txie = 0; m_maint = 0;
    repeat (100) @(negedge clk);
    check("txd_idle_after_reset", txd, 1'b1);
    peek(A_XCSR, 1'b0, r); check("xcsr_after_reset", r, exp_xcsr());
    peek(A_RCSR, 1'b0, r); check("rx_abandoned", r, exp_rcsr());
    peek(A_RBUF, 1'b0, r); check("rbuf_after_reset", r, exp_rbuf());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
